// File: rtl/stream_max_pkg.sv
// Shared definitions for the stream_max extremum tracker: FSM state encoding
// and the bit positions inside the latched mode register.
package stream_max_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int MODE_SIGNED = 0;
    localparam int MODE_MIN    = 1;
    localparam int MODE_W      = 2;

endpackage

// File: rtl/ext_cmp.sv
// Combinational "candidate strictly beats current" test, generalising the
// two-input max comparator to signed/unsigned and max/min.
module ext_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cand,
    input  logic [WIDTH-1:0] cur,
    input  logic             signed_mode,
    input  logic             find_min,
    output logic             better
);

    logic gt;
    logic lt;

    // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
    always_comb begin
        if (signed_mode) begin
            gt = $signed(cand) > $signed(cur);
            lt = $signed(cand) < $signed(cur);
        end else begin
            gt = cand > cur;
            lt = cand < cur;
        end
        // Strict comparison keeps the earliest index on ties.
        better = find_min ? lt : gt;
    end

endmodule

// File: rtl/stream_max.sv
// Framed-stream extremum tracker: reports the max or min sample of a frame
// and the index of its first occurrence, over a valid/ready handshake.
module stream_max
    import stream_max_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             signed_mode,
    input  logic             find_min,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             empty,
    output logic [WIDTH-1:0] ext_val,
    output logic [LEN_W-1:0] ext_idx
);

    logic [1:0]        state;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len_q;
    logic [MODE_W-1:0] mode;
    logic              better;
    logic              accept;
    logic              last;

    assign in_ready = (state == ST_RUN);
    assign busy     = in_ready;
    // A sample coinciding with start belongs to the aborted frame and is dropped.
    assign accept   = in_valid & in_ready & ~start;
    assign last     = (cnt == len_q - LEN_W'(1));

    ext_cmp #(.WIDTH(WIDTH)) u_cmp (
        .cand        (in_data),
        .cur         (ext_val),
        .signed_mode (mode[MODE_SIGNED]),
        .find_min    (mode[MODE_MIN]),
        .better      (better)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            len_q   <= '0;
            mode    <= '0;
            done    <= 1'b0;
            empty   <= 1'b0;
            ext_val <= '0;
            ext_idx <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                len_q             <= len;
                mode[MODE_SIGNED] <= signed_mode;
                mode[MODE_MIN]    <= find_min;
                cnt               <= '0;
                if (len == '0) begin
                    state   <= ST_DONE;
                    done    <= 1'b1;
                    empty   <= 1'b1;
                    ext_val <= '0;
                    ext_idx <= '0;
                end else begin
                    state <= ST_RUN;
                    empty <= 1'b0;
                end
            end else if (accept) begin
                if (cnt == '0 || better) begin
                    ext_val <= in_data;
                    ext_idx <= cnt;
                end
                cnt <= cnt + LEN_W'(1);
                if (last) begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_max.sv
// Self-checking bench for stream_max: a frame-level model (sample buffer plus
// a scan for the extremum) checked every cycle, plus hand-computed expectations.
module tb_stream_max;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] len = '0;
    logic       signed_mode = 1'b0;
    logic       find_min = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, busy, done, empty;
    logic [7:0] ext_val, ext_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc = 0;

    stream_max #(.WIDTH(8), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .signed_mode(signed_mode), .find_min(find_min),
        .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .done(done), .empty(empty),
        .ext_val(ext_val), .ext_idx(ext_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    typedef enum {M_IDLE, M_RUN, M_DONE} m_state_t;
    m_state_t   m_st;
    logic [7:0] m_buf [256];
    int         m_cnt, m_len;
    logic       m_sgn, m_min, m_done, m_empty;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st <= M_IDLE; m_done <= 1'b0; m_cnt <= 0; m_empty <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_len <= int'(len); m_sgn <= signed_mode; m_min <= find_min;
                m_cnt <= 0; m_empty <= (len == 0);
                if (len == 0) begin
                    m_st <= M_DONE; m_done <= 1'b1;
                end else begin
                    m_st <= M_RUN;
                end
            end else if (m_st == M_RUN && in_valid) begin
                m_buf[m_cnt] <= in_data;
                m_cnt <= m_cnt + 1;
                if (m_cnt + 1 == m_len) begin
                    m_st <= M_DONE; m_done <= 1'b1;
                end
            end
        end
    end

    function automatic int key(input logic [7:0] x, input logic sgn);
        return sgn ? int'($signed(x)) : int'(x);
    endfunction

    // Extremum of the recorded frame, first occurrence wins.
    function automatic void ref_ext(output logic [7:0] v, output logic [7:0] idx);
        int best = 0;
        if (m_cnt == 0) begin
            v = 0; idx = 0; return;
        end
        for (int k = 1; k < m_cnt; k++) begin
            if (m_min ? key(m_buf[k], m_sgn) < key(m_buf[best], m_sgn)
                      : key(m_buf[k], m_sgn) > key(m_buf[best], m_sgn))
                best = k;
        end
        v = m_buf[best]; idx = 8'(best);
    endfunction

    always @(negedge clk) begin
        logic [7:0] ev, ei;
        check("in_ready", in_ready, m_st == M_RUN);
        check("busy", busy, m_st == M_RUN);
        check("done", done, m_done);
        if (m_st != M_RUN) begin
            ref_ext(ev, ei);
            check("ext_val", ext_val, ev);
            check("ext_idx", ext_idx, ei);
            check("empty", empty, m_empty);
        end
    end

    // ---------------- drivers ----------------
    task automatic do_start(input int l, input logic s, input logic mn, input logic v, input logic [7:0] d);
        start = 1'b1; len = 8'(l); signed_mode = s; find_min = mn;
        in_valid = v; in_data = d;
        @(negedge clk);
        start_cyc = cyc;
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        in_valid = 1'b1; in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            check("gap_in_ready", in_ready, 1'b1);
        end
    endtask

    task automatic wait_done(output int lat);
        int n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", done, 1'b1);
        lat = cyc - start_cyc + 1;
    endtask

    initial begin
        int lat;
        logic [7:0] frame4 [4];
        frame4 = '{8'h80, 8'h7F, 8'hFF, 8'h01};

        repeat (2) @(negedge clk);
        check("reset_val", ext_val, 0);
        check("reset_ready", in_ready, 0);
        #1 rst = 1'b0;
        @(negedge clk);

        // Unsigned max, tie keeps first index, 6-cycle latency.
        do_start(5, 0, 0, 0, 0);
        send(3, 0); send(9, 0); send(2, 0); send(9, 0); send(7, 0);
        wait_done(lat);
        check("tp1_lat", lat, 6);
        check("tp1_val", ext_val, 9);
        check("tp1_idx", ext_idx, 1);
        @(negedge clk);
        check("tp1_done_drop", done, 0);

        // Signed vs unsigned max on the same frame.
        do_start(4, 1, 0, 0, 0);
        foreach (frame4[i]) send(frame4[i], 0);
        wait_done(lat);
        check("tp2s_val", ext_val, 8'h7F);
        check("tp2s_idx", ext_idx, 1);
        do_start(4, 0, 0, 0, 0);
        foreach (frame4[i]) send(frame4[i], 0);
        wait_done(lat);
        check("tp2u_val", ext_val, 8'hFF);
        check("tp2u_idx", ext_idx, 2);

        // Signed min with stalls.
        do_start(3, 1, 1, 0, 0);
        send(5, 2); send(8'hFB, 2); send(8'hFB, 0);
        wait_done(lat);
        check("tp3_val", ext_val, 8'hFB);
        check("tp3_idx", ext_idx, 1);

        // Empty frame then a single-sample frame.
        do_start(0, 0, 0, 0, 0);
        check("tp4_done", done, 1);
        check("tp4_lat", cyc - start_cyc + 1, 1);
        check("tp4_empty", empty, 1);
        check("tp4_val", ext_val, 0);
        do_start(1, 0, 0, 0, 0);
        send(42, 0);
        wait_done(lat);
        check("tp4b_val", ext_val, 42);
        check("tp4b_idx", ext_idx, 0);
        check("tp4b_empty", empty, 0);

        // Abort after 2 samples; the sample sent alongside start is dropped.
        do_start(5, 0, 0, 0, 0);
        send(100, 0); send(200, 0);
        do_start(3, 0, 0, 1, 250);
        send(1, 0); send(2, 0); send(3, 0);
        wait_done(lat);
        check("abort_val", ext_val, 3);
        check("abort_idx", ext_idx, 2);

        // Start coinciding with the would-be last sample: no done for old frame.
        do_start(2, 0, 0, 0, 0);
        send(50, 0);
        do_start(1, 0, 1, 1, 99);
        check("abort_last_nodone", done, 0);
        send(7, 0);
        wait_done(lat);
        check("abort_last_val", ext_val, 7);

        // Reset mid-frame.
        do_start(5, 0, 0, 0, 0);
        send(11, 0); send(12, 0);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_val", ext_val, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        do_start(2, 0, 0, 0, 0);
        send(4, 0); send(6, 0);
        wait_done(lat);
        check("post_rst_val", ext_val, 6);
        check("post_rst_idx", ext_idx, 1);

        // Sweep: 255-sample frames, both orders, all four modes.
        for (int m = 0; m < 4; m++) begin
            for (int dir = 0; dir < 2; dir++) begin
                do_start(255, m[0], m[1], 0, 0);
                for (int i = 0; i < 255; i++)
                    send(8'(dir == 0 ? i : 254 - i), 0);
                wait_done(lat);
                check("sweep_lat", lat, 256);
                if (m == 1 && dir == 0) begin
                    check("sweep_smax_val", ext_val, 8'h7F);
                    check("sweep_smax_idx", ext_idx, 127);
                end
                if (m == 3 && dir == 1) begin
                    check("sweep_smin_val", ext_val, 8'h80);
                    check("sweep_smin_idx", ext_idx, 126);
                end
            end
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_max.md
# stream_max

Sequential, parametrised extremum tracker. It consumes a framed stream of WIDTH-bit samples over a valid/ready handshake and reports the maximum, or the minimum, together with the index of its first occurrence. Comparison can be unsigned or two's-complement signed. It is the clocked, multi-sample successor to the two-input combinational maximum comparator, and it sits behind sample producers (ADC capture, counters, test pattern sources) in the lab datapaths.

## Interface
Parameters:
- WIDTH, 8: sample width in bits.
- LEN_W, 8: width of the frame-length and index fields. Maximum frame length is 2^LEN_W − 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  begin a new frame; sampled on the rising edge.
- len  in  LEN_W  frame length in samples; latched with start.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; latched with start.
- find_min  in  1  1 = track minimum, 0 = track maximum; latched with start.
- in_valid  in  1  sample present on in_data.
- in_data  in  WIDTH  sample value.
- in_ready  out  1  high exactly while in RUN.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on entry to DONE.
- empty  out  1  frame had len = 0; valid while in DONE.
- ext_val  out  WIDTH  extremum value; registered.
- ext_idx  out  LEN_W  0-based index of first occurrence of ext_val; registered.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start = 1, len ≠ 0 → RUN. Latch len, signed_mode and find_min; clear cnt; clear empty.
  - start = 1, len = 0 → DONE. ext_val = 0, ext_idx = 0, empty = 1.
- RUN:
  - A sample is accepted when in_valid & in_ready.
  - First sample (cnt = 0) is loaded unconditionally: ext_val = in_data, ext_idx = 0.
  - Each later sample replaces the extremum only if it is strictly greater (max mode) or strictly less (min mode). Ties keep the earlier index.
  - cnt increments per accepted sample. Acceptance with cnt = len − 1 → DONE.
  - in_valid = 0 stalls the frame with no state change. There is no timeout.
- DONE:
  - ext_val, ext_idx and empty hold.
  - start → same transitions as from IDLE.
- start while in RUN aborts the current frame and restarts with the new len and modes. A sample presented in that same cycle is discarded.
- Signed compare: MSB is the sign bit. In signed max mode, 8'h7F > 8'h80. In unsigned max mode, 8'h80 > 8'h7F.
- cnt is LEN_W bits wide and never wraps, because len ≤ 2^LEN_W − 1.
- in_valid is ignored in IDLE and DONE.

## Timing
- Reset values: state = IDLE, in_ready = 0, busy = 0, done = 0, empty = 0, ext_val = 0, ext_idx = 0, cnt = 0.
- rst asserted at any point, including mid-frame, clears all state immediately and abandons the frame. No done pulse is generated.
- start at edge k → in_ready = 1 from k+1.
- Last sample accepted at edge m → done = 1 and final ext_val/ext_idx visible during cycle m+1 (1-cycle latency). done = 0 at m+2.
- Fully back-to-back frame of L samples: start edge to done = L+1 cycles.
- len = 0: done pulses in the cycle after the start edge, with empty = 1.
- start and the last sample arriving together while in RUN: start wins, and no done pulse is generated for the aborted frame.

## Structure
- Shared package stream_max_pkg:
  - State encoding constants ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2.
  - Mode bit positions.
- Sub-module ext_cmp (WIDTH parameter), purely combinational:
  - Inputs: cand, cur, signed_mode, find_min.
  - Output: better, which is 1 iff cand strictly beats cur.
  - Implemented as the signed/unsigned, max/min generalisation of the two-input comparator.
- Top level contains the FSM, counter, mode latches and output registers.

## Test plan
- Unsigned max, len = 5, samples 3, 9, 2, 9, 7 → done after 6 cycles; ext_val = 9, ext_idx = 1 (tie keeps first).
- Signed max, len = 4, samples 8'h80, 8'h7F, 8'hFF, 8'h01 → ext_val = 8'h7F, ext_idx = 1. Same frame with unsigned max → ext_val = 8'hFF, ext_idx = 2.
- Signed min, len = 3, samples 5, 8'hFB, 8'hFB with in_valid gaps of 2 cycles between samples → ext_val = 8'hFB, ext_idx = 1; in_ready stays 1 throughout the frame.
- len = 0 → done one cycle after start, empty = 1, ext_val = 0. Then len = 1 with sample 42 → ext_val = 42, ext_idx = 0, empty = 0.
- Abort and reset:
  - start again after 2 of 5 samples → the new frame result excludes the old samples.
  - rst pulse mid-frame → all outputs 0 and state IDLE with no done pulse.
  - A following start works normally.
- Exhaustive sweep with WIDTH = 8, len = 255, values 0..254 in both orders and all four modes → ext_val and ext_idx match the reference model, and the counter does not wrap.
